// File: rtl/param_dualport_ram.sv
`default_nettype none
// ============================================================================
// param_dualport_ram : parametrised simple dual-port RAM with zero-fill
// Revision 1.0
// ============================================================================
module param_dualport_ram #(
  parameter int BW        = 16,
  parameter int ADDR_W    = 5,
  parameter int OUT_REG   = 0,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [ADDR_W-1:0] addr_r,
  input  logic [BW-1:0]     data_in,
  output logic [BW-1:0]     data_out,
  output logic              rd_valid,
  output logic              init_busy
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_busy;
  logic [BW-1:0]     r_mem [c_DEPTH];
  logic [BW-1:0]     r_s1_data;
  logic              r_s1_v;

  logic              w_idle;
  logic              w_user_wr;
  logic              w_user_rd;
  logic              w_collide;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [BW-1:0]     w_mem_din;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_user_wr  = w_idle && valid && we;
  assign w_user_rd  = w_idle && valid && re;
  assign w_collide  = w_user_wr && w_user_rd && (addr_w == addr_r);
  // The write port is shared by the zero-fill sequencer and the user.
  assign w_mem_we   = rst_n && (!w_idle || w_user_wr);
  assign w_mem_addr = w_idle ? addr_w : r_init_cnt;
  assign w_mem_din  = w_idle ? data_in : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      r_init_busy <= (INIT_ZERO != 0);
      r_init_cnt  <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == {ADDR_W{1'b1}}) begin
        r_state     <= ST_IDLE;
        r_init_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_v <= w_user_rd;
      if (w_user_rd) begin
        r_s1_data <= ((RDW_MODE != 0) && w_collide) ? data_in : r_mem[addr_r];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [BW-1:0] r_dout;
      logic          r_rv;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_dout <= '0;
          r_rv   <= 1'b0;
        end else begin
          r_rv <= r_s1_v;
          if (r_s1_v) begin
            r_dout <= r_s1_data;
          end
        end
      end

      assign data_out = r_dout;
      assign rd_valid = r_rv;
    end else begin : g_no_out_reg
      assign data_out = r_s1_data;
      assign rd_valid = r_s1_v;
    end
  endgenerate

  assign init_busy = r_init_busy;

endmodule
`default_nettype wire

// File: tb/tb_param_dualport_ram.sv
`default_nettype none
// ============================================================================
// tb_param_dualport_ram : directed + random check of two RAM configurations
// Revision 1.0
// ============================================================================
module tb_param_dualport_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [4:0]  addr_w = '0;
  logic [4:0]  addr_r = '0;
  logic [15:0] data_in = '0;

  logic [15:0] a_dout, b_dout;
  logic        a_rv, b_rv, a_busy, b_busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] mdl_mem [32];
  int          init_left = 0;
  logic        exp_a_v = 1'b0, exp_b_v = 1'b0, pend_b_v = 1'b0;
  logic [15:0] exp_a_d = '0, exp_b_d = '0, pend_b_d = '0;
  logic        exp_busy = 1'b1;

  always #5 clk = ~clk;

  param_dualport_ram #(.BW(16), .ADDR_W(5), .OUT_REG(0), .RDW_MODE(0), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid(valid), .we(we), .re(re),
    .addr_w(addr_w), .addr_r(addr_r), .data_in(data_in),
    .data_out(a_dout), .rd_valid(a_rv), .init_busy(a_busy)
  );

  param_dualport_ram #(.BW(16), .ADDR_W(5), .OUT_REG(1), .RDW_MODE(1), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid), .we(we), .re(re),
    .addr_w(addr_w), .addr_r(addr_r), .data_in(data_in),
    .data_out(b_dout), .rd_valid(b_rv), .init_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare both DUTs.
  task automatic step(input logic rn, input logic v, input logic w, input logic r,
                      input logic [4:0] aw, input logic [4:0] ar, input logic [15:0] d);
    logic        rq_v;
    logic [15:0] old_d;
    logic [15:0] new_d;
    rq_v  = 1'b0;
    old_d = '0;
    new_d = '0;
    rst_n = rn; valid = v; we = w; re = r; addr_w = aw; addr_r = ar; data_in = d;
    @(posedge clk);
    if (!rn) begin
      init_left = 32;
      exp_a_v = 1'b0; exp_a_d = '0;
      exp_b_v = 1'b0; exp_b_d = '0;
      pend_b_v = 1'b0; pend_b_d = '0;
    end else begin
      if (init_left > 0) begin
        mdl_mem[32 - init_left] = '0;
        init_left--;
      end else if (v) begin
        old_d = mdl_mem[ar];
        new_d = (w && aw == ar) ? d : old_d;
        rq_v  = r;
        if (w) mdl_mem[aw] = d;
      end
      exp_a_v = rq_v;
      if (rq_v) exp_a_d = old_d;
      exp_b_v = pend_b_v;
      if (pend_b_v) exp_b_d = pend_b_d;
      pend_b_v = rq_v;
      pend_b_d = new_d;
    end
    exp_busy = (init_left > 0);
    #1;
    chk("a_rd_valid",  {15'b0, a_rv},   {15'b0, exp_a_v});
    chk("a_data_out",  a_dout,          exp_a_d);
    chk("a_init_busy", {15'b0, a_busy}, {15'b0, exp_busy});
    chk("b_rd_valid",  {15'b0, b_rv},   {15'b0, exp_b_v});
    chk("b_data_out",  b_dout,          exp_b_d);
    chk("b_init_busy", {15'b0, b_busy}, {15'b0, exp_busy});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
  endtask

  initial begin
    int busy_a, busy_b, pulses_a, pulses_b, run_b;
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;

    // Reset state, then a first fill with user traffic being dropped
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 16'h1111);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 5'(i), 5'(i), 16'hDEAD);

    // Dirty the whole array, reset, and measure the zero-fill window
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 5'(i), 5'd0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    busy_a = int'(a_busy);
    busy_b = int'(b_busy);
    for (int i = 0; i < 40; i++) begin
      idle();
      busy_a += int'(a_busy);
      busy_b += int'(b_busy);
    end
    chk("a_busy_cycles", 16'(busy_a), 16'd32);
    chk("b_busy_cycles", 16'(busy_b), 16'd32);

    pulses_a = 0;
    pulses_b = 0;
    for (int i = 0; i < 34; i++) begin
      if (i < 32) step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'(i), 16'h0);
      else idle();
      pulses_a += int'(a_rv);
      pulses_b += int'(b_rv);
    end
    chk("a_zero_pulses", 16'(pulses_a), 16'd32);
    chk("b_zero_pulses", 16'(pulses_b), 16'd32);

    // Write then read, data_out must hold afterwards
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd3, 16'h0);
    chk("a_wr_rd", a_dout, 16'h1234);
    for (int i = 0; i < 3; i++) idle();
    chk("a_hold", a_dout, 16'h1234);
    chk("b_hold", b_dout, 16'h1234);

    // Same-address collision
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 16'hAAAA);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 16'h5555);
    chk("a_collide_old", a_dout, 16'hAAAA);
    idle();
    chk("b_collide_new", b_dout, 16'h5555);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd7, 16'h0);
    chk("a_after_collide", a_dout, 16'h5555);
    idle();
    chk("b_after_collide", b_dout, 16'h5555);

    // valid low blocks both ports
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 16'h4321);
    step(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 16'h0F0F);
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd9, 16'h0);
    chk("a_valid_low", a_dout, 16'h4321);
    idle();

    // Back-to-back reads through the pipelined instance
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 5'(i), 5'd0, 16'(i * 3));
    run_b = 0;
    for (int i = 0; i < 34; i++) begin
      if (i < 32) step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'(i), 16'h0);
      else idle();
      if (i >= 1 && i <= 32 && b_rv) run_b++;
    end
    chk("b_stream_run", 16'(run_b), 16'd32);
    chk("b_stream_last", b_dout, 16'd93);

    // Reset in the middle of the fill, with a user write that must be dropped
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) step(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 16'hBEEF);
      else idle();
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    busy_a = int'(a_busy);
    for (int i = 0; i < 36; i++) begin
      if (i == 5) step(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 16'hBEEF);
      else idle();
      busy_a += int'(a_busy);
    end
    chk("a_restart_busy", 16'(busy_a), 16'd32);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd5, 16'h0);
    chk("a_dropped_wr", a_dout, 16'h0);
    idle();
    chk("b_dropped_wr", b_dout, 16'h0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 99) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)),
           16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_dualport_ram.md
Name: param_dualport_ram

Overview:
- Parametrised simple dual-port RAM for the in-place FFT data/twiddle buffers. Next generation of the fixed 32-entry buffer.
- Adds configurable width and depth, an optional output pipeline register, and a selectable read-during-write policy.
- Adds a read-valid tag pipeline and a post-reset zero-initialisation sequencer, so stage controllers can start on a known-clean buffer.
- Sits between the FFT stage controller (address generation) and the butterfly datapath.

Parameters:
- BW, 16, data word width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- OUT_REG, 0, 1 inserts an extra output register stage; read latency = 1 + OUT_REG.
- RDW_MODE, 0, same-address read/write collision policy: 0 returns old data, 1 returns new (write-through) data.
- INIT_ZERO, 1, 1 zero-fills every entry after reset; 0 disables the sequencer.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- valid  input  1  global qualifier; we/re are ignored when low.
- we  input  1  write enable.
- re  input  1  read enable.
- addr_w  input  ADDR_W  write address.
- addr_r  input  ADDR_W  read address.
- data_in  input  BW  write data.
- data_out  output  BW  read data; holds its value between reads.
- rd_valid  output  1  one-cycle pulse aligned with new data_out.
- init_busy  output  1  high while the zero-fill is in progress; user accesses are dropped.

Behaviour:
- Reset (rst_n low at posedge):
  - data_out=0, rd_valid=0, internal stage-1 data/valid=0.
  - init_cnt=0; state=INIT if INIT_ZERO else IDLE; init_busy=INIT_ZERO.
  - No memory write occurs during a reset cycle. Array contents are not otherwise reset.
- FSM states: INIT, IDLE.
  - INIT: each cycle write ram[init_cnt]<=0, init_cnt++.
  - When init_cnt==DEPTH-1, that write completes and state->IDLE; init_busy goes low the following cycle.
  - Zero-fill takes exactly DEPTH cycles after the first posedge with rst_n high.
  - IDLE is terminal until the next reset.
- During INIT: user we/re are ignored, rd_valid=0, data_out holds 0.
- Write: in IDLE, when valid&&we at posedge, ram[addr_w]<=data_in.
- Read stage 1: in IDLE, when valid&&re at posedge, s1_data<=ram[addr_r] and s1_v<=1; else s1_v<=0 and s1_data holds.
- Collision: valid&&we&&re&&addr_w==addr_r in the same cycle.
  - RDW_MODE=0: s1_data gets the pre-write contents.
  - RDW_MODE=1: s1_data gets data_in.
  - The write always commits.
- OUT_REG=0: data_out=s1_data, rd_valid=s1_v. Latency 1 cycle from the read-request edge.
- OUT_REG=1: data_out<=s1_data only when s1_v; rd_valid<=s1_v. Latency 2 cycles; full throughput, one read per cycle.
- Writes and reads are fully independent otherwise; one of each per cycle.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range access exists. init_cnt is ADDR_W+1 bits or uses terminal-compare to avoid overflow.
- Reset mid-INIT: the sequencer restarts from address 0 and init_busy stays high continuously. The full DEPTH cycles are required again after release.
- Reset mid-read: pending stage-1/stage-2 data is discarded and rd_valid=0. No stale pulse after release.
- valid low: no write, no read, rd_valid=0 next cycle, data_out unchanged.

Test Plan:
- INIT_ZERO=1, ADDR_W=5: preload RAM with 0xFFFF via backdoor, release rst_n -> init_busy high exactly 32 cycles; then read addr 0..31 -> all 0x0000, rd_valid pulses 32 times.
- OUT_REG=0: write 0x1234 @addr 3 at cycle T, read addr 3 at T+1 -> data_out=0x1234 and rd_valid=1 at T+2 only; data_out still 0x1234 at T+5.
- Collision: ram[7]=0xAAAA, then at the same edge write 0x5555 @7 and read @7 -> RDW_MODE=0 gives 0xAAAA, RDW_MODE=1 gives 0x5555; a subsequent read @7 gives 0x5555 in both modes.
- valid=0 with we=re=1, addr 9, data 0x0F0F -> ram[9] unchanged (later read gives prior value), rd_valid stays 0, data_out unchanged.
- OUT_REG=1: back-to-back reads addr 0..31 holding data k*3 -> data_out sequence 0,3,...,93 starting 2 cycles after the first request, rd_valid high for 32 consecutive cycles.
- Reset asserted at INIT cycle 10, held 2 cycles, released -> init_busy never drops, and stays high 32 more cycles; user write attempted during INIT is dropped (location reads 0).
